// File: rtl/spart_rx_fifo.sv
// Oversampled asynchronous serial receiver feeding a first-word-fall-through receive FIFO.
// Optional even-parity checking is compiled in when PARITY_CHECK_EN is defined.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RxD,
    input  logic                   baud_en,
    input  logic                   rd_rx,
    output logic [DATA_BITS-1:0]   RxD_data,
    output logic                   RDA,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frm_err,
    output logic                   ovr_err,
    input  logic                   clr_err
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low sample
    // START  | timing to mid start bit to confirm it is real
    // DATA   | sampling DATA_BITS data bits, LSB first
    // PARITY | sampling the parity bit (PARITY_CHECK_EN builds only)
    // STOP   | sampling the stop bit, then push or flag a framing error
    // BRK    | bad stop bit seen, waiting for the line to return high
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [1:0]           sync_q, sync_d;
    logic                 rxs;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 tick_zero, bit_zero;
    logic                 frm_set;
    logic                 par_ok;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_push, do_pop, full, ovr_set;

    logic                 frm_err_q, frm_err_d;
    logic                 ovr_err_q, ovr_err_d;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_comb begin
        sync_d = {sync_q[0], RxD};
    end

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign tick_zero = (tick_q == '0);
    assign bit_zero  = (bit_q == '0);

`ifdef PARITY_CHECK_EN
    logic par_bad_q, par_bad_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad_q <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
        end
    end

    assign par_ok = ~par_bad_q;
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (baud_en) begin
            case (state_q)
                IDLE:   if (!rxs) state_d = START;
                START:  if (tick_zero) state_d = rxs ? IDLE : DATA;
                DATA: begin
                    if (tick_zero && bit_zero) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY: if (tick_zero) state_d = STOP;
                STOP:   if (tick_zero) state_d = rxs ? IDLE : BRK;
                BRK:    if (rxs) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Tick timer is a down-counter: each sampling state fires on terminal count.
    always_comb begin
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        frm_set = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_d = par_bad_q;
`endif
        if (baud_en) begin
            case (state_q)
                IDLE: tick_d = TICK_HALF;
                START: begin
                    tick_d = tick_zero ? TICK_FULL : tick_q - 1'b1;
                    if (tick_zero) bit_d = BIT_LAST;
                end
                DATA: begin
                    tick_d = tick_zero ? TICK_FULL : tick_q - 1'b1;
                    if (tick_zero) begin
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        if (!bit_zero) bit_d = bit_q - 1'b1;
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    tick_d = tick_zero ? TICK_FULL : tick_q - 1'b1;
                    if (tick_zero) par_bad_d = ^{shift_q, rxs};
                end
`endif
                STOP: begin
                    tick_d = tick_zero ? TICK_FULL : tick_q - 1'b1;
                    if (tick_zero) begin
                        if (rxs && par_ok) push_d = 1'b1;
                        else               frm_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    // shift_q is stable for at least half a bit after the stop sample, so it
    // can be written one clock later without a separate holding register.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full     = (count_q == FULL_CNT);
        do_pop   = rd_rx && (count_q != '0);
        do_push  = push_q && (!full || do_pop);
        ovr_set  = push_q && full && !do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A new error event beats a simultaneous clear.
    always_comb begin
        frm_err_d = frm_set | (frm_err_q & ~clr_err);
        ovr_err_d = ovr_set | (ovr_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    assign RxD_data = mem_q[rd_ptr_q];
    assign RDA      = (count_q != '0);
    assign count    = count_q;
    assign frm_err  = frm_err_q;
    assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Randomised bench for spart_rx_fifo against a queue-based model of frames, FIFO and sticky errors.
// Define PARITY_CHECK_EN for both bench and design to exercise the parity build.
module tb_spart_rx_fifo;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int DEPTH      = 4;
    localparam int CW         = $clog2(DEPTH) + 1;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b0;
    logic                 RxD     = 1'b1;
    logic                 baud_en = 1'b1;
    logic                 rd_rx   = 1'b0;
    logic                 clr_err = 1'b0;
    logic [DATA_BITS-1:0] RxD_data;
    logic                 RDA;
    logic [CW-1:0]        count;
    logic                 frm_err;
    logic                 ovr_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_BITS-1:0] exp_q [$];
    logic                 exp_frm = 1'b0;
    logic                 exp_ovr = 1'b0;

    spart_rx_fifo #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .RxD     (RxD),
        .baud_en (baud_en),
        .rd_rx   (rd_rx),
        .RxD_data(RxD_data),
        .RDA     (RDA),
        .count   (count),
        .frm_err (frm_err),
        .ovr_err (ovr_err),
        .clr_err (clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_frame(input logic [DATA_BITS-1:0] d, input bit ok);
        if (!ok)                        exp_frm = 1'b1;
        else if (exp_q.size() == DEPTH) exp_ovr = 1'b1;
        else                            exp_q.push_back(d);
    endfunction

    function automatic void model_pop();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endfunction

    // strobe[0] pops and strobe[1] clears errors on the clock edge that pushes the frame.
    task automatic send_frame(input logic [DATA_BITS-1:0] data, input bit stop_bit,
                              input bit bad_par, input logic [1:0] strobe);
        RxD = 1'b0;
        tick(OVERSAMPLE);
        for (int i = 0; i < DATA_BITS; i++) begin
            RxD = data[i];
            tick(OVERSAMPLE);
        end
`ifdef PARITY_CHECK_EN
        RxD = (^data) ^ bad_par;
        tick(OVERSAMPLE);
`endif
        RxD = stop_bit;
        if (strobe != 2'b00) begin
            tick(11);
            rd_rx   = strobe[0];
            clr_err = strobe[1];
            tick(1);
            rd_rx   = 1'b0;
            clr_err = 1'b0;
            tick(OVERSAMPLE - 12);
        end else begin
            tick(OVERSAMPLE);
        end
        if (strobe[1]) begin
            exp_frm = 1'b0;
            exp_ovr = 1'b0;
        end
        if (strobe[0]) model_pop();
        model_frame(data, stop_bit && !(bad_par && PAR_EN));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            RxD = 1'($urandom_range(0, 1));
        end
        tests_run++; if (RDA !== 1'b0)      begin tests_failed++; $display("FAIL reset_rda: got %b want 0", RDA); end
        tests_run++; if (count !== '0)      begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== 1'b0)  begin tests_failed++; $display("FAIL reset_frm: got %b want 0", frm_err); end
        tests_run++; if (ovr_err !== 1'b0)  begin tests_failed++; $display("FAIL reset_ovr: got %b want 0", ovr_err); end
        tests_run++; if (RxD_data !== '0)   begin tests_failed++; $display("FAIL reset_data: got %0h want 0", RxD_data); end
        @(negedge clk);
        RxD = 1'b1;
        rst = 1'b1;
        tick(100);
        tests_run++; if (RDA !== 1'b0)      begin tests_failed++; $display("FAIL idle_rda: got %b want 0", RDA); end
        tests_run++; if (count !== '0)      begin tests_failed++; $display("FAIL idle_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== 1'b0)  begin tests_failed++; $display("FAIL idle_frm: got %b want 0", frm_err); end
        tests_run++; if (ovr_err !== 1'b0)  begin tests_failed++; $display("FAIL idle_ovr: got %b want 0", ovr_err); end
    endtask

    // Start edge reaches the FSM 3 clocks later; start sample at clock 11, so the
    // stop sample falls 11 clocks into the stop bit and RDA rises one clock after it.
    task automatic test_single_frame();
        logic [DATA_BITS-1:0] d;
        d = 8'hA5;
        RxD = 1'b0;
        tick(OVERSAMPLE);
        for (int i = 0; i < DATA_BITS; i++) begin
            RxD = d[i];
            tick(OVERSAMPLE);
        end
`ifdef PARITY_CHECK_EN
        RxD = ^d;
        tick(OVERSAMPLE);
`endif
        RxD = 1'b1;
        tick(11);
        tests_run++; if (RDA !== 1'b0)     begin tests_failed++; $display("FAIL single_rda_early: got %b want 0", RDA); end
        tick(1);
        tests_run++; if (RDA !== 1'b1)     begin tests_failed++; $display("FAIL single_rda: got %b want 1", RDA); end
        tests_run++; if (RxD_data !== d)   begin tests_failed++; $display("FAIL single_data: got %0h want %0h", RxD_data, d); end
        tests_run++; if (count !== CW'(1)) begin tests_failed++; $display("FAIL single_count: got %0d want 1", count); end
        tick(OVERSAMPLE - 12);
        model_frame(d, 1'b1);
        rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
        tests_run++; if (RDA !== 1'b0)     begin tests_failed++; $display("FAIL single_pop_rda: got %b want 0", RDA); end
        tests_run++; if (count !== '0)     begin tests_failed++; $display("FAIL single_pop_count: got %0d want 0", count); end
        rd_rx = 1'b1; tick(1); rd_rx = 1'b0;
        tests_run++; if (count !== '0)     begin tests_failed++; $display("FAIL empty_pop_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL single_frm: got %b want 0", frm_err); end
    endtask

    task automatic test_false_start();
        RxD = 1'b0;
        tick(4);
        RxD = 1'b1;
        tick(30);
        tests_run++; if (count !== '0)     begin tests_failed++; $display("FAIL false_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL false_frm: got %b want 0", frm_err); end
        send_frame(8'h3C, 1'b1, 1'b0, 2'b00);
        tick(5);
        tests_run++; if (count !== CW'(1))  begin tests_failed++; $display("FAIL false_next_count: got %0d want 1", count); end
        tests_run++; if (RxD_data !== 8'h3C) begin tests_failed++; $display("FAIL false_next_data: got %0h want 3c", RxD_data); end
        rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
    endtask

    task automatic test_framing_error();
        send_frame(8'h55, 1'b0, 1'b0, 2'b00);
        tick(40);
        tests_run++; if (count !== '0)     begin tests_failed++; $display("FAIL frm_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== exp_frm) begin tests_failed++; $display("FAIL frm_flag: got %b want %b", frm_err, exp_frm); end
        RxD = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b1, 1'b0, 2'b00);
        tick(3);
        tests_run++; if (count !== CW'(exp_q.size())) begin tests_failed++; $display("FAIL frm_next_count: got %0d want %0d", count, exp_q.size()); end
        tests_run++; if (RxD_data !== 8'h81) begin tests_failed++; $display("FAIL frm_next_data: got %0h want 81", RxD_data); end
        tests_run++; if (frm_err !== 1'b1)   begin tests_failed++; $display("FAIL frm_sticky: got %b want 1", frm_err); end
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        tests_run++; if (frm_err !== 1'b0)   begin tests_failed++; $display("FAIL frm_clear: got %b want 0", frm_err); end
        rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
    endtask

    task automatic test_overrun_wrap();
        for (int i = 1; i <= 5; i++) begin
            send_frame(DATA_BITS'(i), 1'b1, 1'b0, 2'b00);
            tick(2);
        end
        tests_run++; if (count !== CW'(DEPTH)) begin tests_failed++; $display("FAIL ovr_count: got %0d want %0d", count, DEPTH); end
        tests_run++; if (ovr_err !== 1'b1)     begin tests_failed++; $display("FAIL ovr_flag: got %b want 1", ovr_err); end
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (RxD_data !== DATA_BITS'(i)) begin
                tests_failed++; $display("FAIL ovr_pop%0d: got %0h want %0h", i, RxD_data, DATA_BITS'(i));
            end
            rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
        end
        tests_run++; if (RDA !== 1'b0) begin tests_failed++; $display("FAIL ovr_drained: got %b want 0", RDA); end
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        tests_run++; if (ovr_err !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", ovr_err); end
        repeat (DEPTH) begin
            send_frame(DATA_BITS'($urandom), 1'b1, 1'b0, 2'b00);
            tick(2);
        end
        send_frame(DATA_BITS'($urandom), 1'b1, 1'b0, 2'b10);
        tick(2);
        tests_run++; if (ovr_err !== exp_ovr) begin tests_failed++; $display("FAIL ovr_set_wins: got %b want %b", ovr_err, exp_ovr); end
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
        send_frame(8'h06, 1'b1, 1'b0, 2'b01);
        tick(2);
        tests_run++; if (count !== CW'(exp_q.size())) begin tests_failed++; $display("FAIL full_pushpop_count: got %0d want %0d", count, exp_q.size()); end
        tests_run++; if (ovr_err !== 1'b0) begin tests_failed++; $display("FAIL full_pushpop_ovr: got %b want 0", ovr_err); end
        while (exp_q.size() > 0) begin
            tests_run++;
            if (RxD_data !== exp_q[0]) begin
                tests_failed++; $display("FAIL full_order: got %0h want %0h", RxD_data, exp_q[0]);
            end
            rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
        end
        tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL full_drain_count: got %0d want 0", count); end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b0, 2'b00);
        tick(2);
        tests_run++; if (count !== CW'(1))   begin tests_failed++; $display("FAIL par_good_count: got %0d want 1", count); end
        tests_run++; if (RxD_data !== 8'h07) begin tests_failed++; $display("FAIL par_good_data: got %0h want 07", RxD_data); end
        tests_run++; if (frm_err !== 1'b0)   begin tests_failed++; $display("FAIL par_good_frm: got %b want 0", frm_err); end
        send_frame(8'h07, 1'b1, 1'b1, 2'b00);
        tick(2);
        tests_run++; if (count !== CW'(1))   begin tests_failed++; $display("FAIL par_bad_count: got %0d want 1", count); end
        tests_run++; if (frm_err !== 1'b1)   begin tests_failed++; $display("FAIL par_bad_frm: got %b want 1", frm_err); end
        rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
        clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
    endtask
`endif

    task automatic test_random_traffic();
        logic [DATA_BITS-1:0] d;
        bit                   stop_ok;
        bit                   bad_par;
        int                   npop;
        repeat (14) begin
            d       = DATA_BITS'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            bad_par = ($urandom_range(0, 5) == 0);
            send_frame(d, stop_ok, bad_par, 2'b00);
            RxD = 1'b1;
            tick($urandom_range(4, 12));
            tests_run++; if (count !== CW'(exp_q.size())) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", count, exp_q.size()); end
            tests_run++; if (RDA !== (exp_q.size() != 0)) begin tests_failed++; $display("FAIL rand_rda: got %b want %b", RDA, exp_q.size() != 0); end
            tests_run++; if (frm_err !== exp_frm) begin tests_failed++; $display("FAIL rand_frm: got %b want %b", frm_err, exp_frm); end
            tests_run++; if (ovr_err !== exp_ovr) begin tests_failed++; $display("FAIL rand_ovr: got %b want %b", ovr_err, exp_ovr); end
            if (exp_q.size() > 0) begin
                tests_run++;
                if (RxD_data !== exp_q[0]) begin
                    tests_failed++; $display("FAIL rand_head: got %0h want %0h", RxD_data, exp_q[0]);
                end
            end
            npop = $urandom_range(0, 2);
            repeat (npop) begin
                rd_rx = 1'b1; tick(1); rd_rx = 1'b0; model_pop();
            end
            if ($urandom_range(0, 3) == 0) begin
                clr_err = 1'b1; tick(1); clr_err = 1'b0; exp_frm = 1'b0; exp_ovr = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hC3, 1'b1, 1'b0, 2'b00);
        tick(2);
        tests_run++; if (RDA !== (exp_q.size() != 0)) begin tests_failed++; $display("FAIL mid_pre_rda: got %b want %b", RDA, exp_q.size() != 0); end
        RxD = 1'b0;
        tick(50);
        rst = 1'b0;
        #1;
        exp_q.delete(); exp_frm = 1'b0; exp_ovr = 1'b0;
        tests_run++; if (count !== '0)    begin tests_failed++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        tests_run++; if (RDA !== 1'b0)    begin tests_failed++; $display("FAIL mid_rst_rda: got %b want 0", RDA); end
        tests_run++; if (RxD_data !== '0) begin tests_failed++; $display("FAIL mid_rst_data: got %0h want 0", RxD_data); end
        tick(2);
        RxD = 1'b1;
        rst = 1'b1;
        tick(200);
        tests_run++; if (count !== '0)     begin tests_failed++; $display("FAIL mid_after_count: got %0d want 0", count); end
        tests_run++; if (frm_err !== 1'b0) begin tests_failed++; $display("FAIL mid_after_frm: got %b want 0", frm_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_false_start();
        test_framing_error();
        test_overrun_wrap();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random_traffic();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
